// File: rtl/fixed_matmul_pkg.sv
// Shared width helpers for the tiled fixed-point matrix multiplier.
package fixed_matmul_pkg;

    // Accumulator width that holds IN_DEPTH beats of IN_COLUMNS-long dot products.
    function automatic int unsigned acc_width(int unsigned in_w, int unsigned w_w,
                                              int unsigned cols, int unsigned depth);
        return in_w + w_w + $clog2(cols) + $clog2(depth);
    endfunction

    // One guard bit so the half-LSB rounding add cannot wrap.
    function automatic int unsigned round_width(int unsigned acc_w);
        return acc_w + 1;
    endfunction

    function automatic int unsigned sat_width(int unsigned acc_w, int unsigned out_w);
        return ((acc_w + 1 > out_w) ? acc_w + 1 : out_w) + 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational per-element conversion: round-half-up shift, then saturate or truncate.
module fixed_round_sat
    import fixed_matmul_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 20,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SHIFT     = 4,
    parameter int unsigned SATURATE  = 1
) (
    input  logic [IN_WIDTH-1:0]  acc,
    output logic [OUT_WIDTH-1:0] result
);

    localparam int unsigned RW = round_width(IN_WIDTH);
    localparam int unsigned SW = sat_width(IN_WIDTH, OUT_WIDTH);
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] shifted;
    logic signed [SW-1:0] wide;

    assign ext = {acc[IN_WIDTH-1], acc};

    if (SHIFT > 0) begin : g_round
        localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
        assign shifted = (ext + HALF) >>> SHIFT;
    end else begin : g_no_round
        assign shifted = ext;
    end

    assign wide = {{(SW-RW){shifted[RW-1]}}, shifted};

    always_comb begin
        result = wide[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (wide > MAX_V) begin
                result = MAX_V[OUT_WIDTH-1:0];
            end else if (wide < MIN_V) begin
                result = MIN_V[OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fixed_matmul_tiled.sv
// Streaming signed matrix multiplier: jointly handshaked A/B tile beats accumulate into C,
// which is rounded, saturated and held in an output register for downstream.
module fixed_matmul_tiled
    import fixed_matmul_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned WEIGHT_WIDTH   = 8,
    parameter int unsigned IN_ROWS        = 4,
    parameter int unsigned IN_COLUMNS     = 4,
    parameter int unsigned WEIGHT_COLUMNS = 4,
    parameter int unsigned IN_DEPTH       = 3,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned OUT_SHIFT      = 4,
    parameter int unsigned SATURATE       = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [IN_ROWS*IN_COLUMNS*IN_WIDTH-1:0]       data_in,
    input  logic                                         data_in_valid,
    output logic                                         data_in_ready,
    input  logic [IN_COLUMNS*WEIGHT_COLUMNS*WEIGHT_WIDTH-1:0] weight,
    input  logic                                         weight_valid,
    output logic                                         weight_ready,
    output logic [IN_ROWS*WEIGHT_COLUMNS*OUT_WIDTH-1:0]  data_out,
    output logic                                         data_out_valid,
    input  logic                                         data_out_ready
);

    localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, WEIGHT_WIDTH, IN_COLUMNS, IN_DEPTH);
    localparam int unsigned CNT_WIDTH = cnt_width(IN_DEPTH);
    localparam int unsigned PW        = IN_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned NUM_A     = IN_ROWS * IN_COLUMNS;
    localparam int unsigned NUM_B     = IN_COLUMNS * WEIGHT_COLUMNS;
    localparam int unsigned NUM_C     = IN_ROWS * WEIGHT_COLUMNS;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(IN_DEPTH - 1);

    logic [CNT_WIDTH-1:0]        beat_cnt_q, beat_cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_C];
    logic signed [ACC_WIDTH-1:0] acc_d [NUM_C];
    logic signed [ACC_WIDTH-1:0] final_sum [NUM_C];
    logic [OUT_WIDTH-1:0]        conv [NUM_C];
    logic [NUM_C*OUT_WIDTH-1:0]  out_q, out_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [IN_WIDTH-1:0]     a_el [NUM_A];
    logic signed [WEIGHT_WIDTH-1:0] b_el [NUM_B];
    logic signed [PW-1:0]           prod [NUM_C*IN_COLUMNS];
    logic last_beat, can_accept, beat;

    for (genvar i = 0; i < NUM_A; i++) begin : g_a
        assign a_el[i] = data_in[i*IN_WIDTH +: IN_WIDTH];
    end
    for (genvar i = 0; i < NUM_B; i++) begin : g_b
        assign b_el[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    for (genvar r = 0; r < IN_ROWS; r++) begin : g_row
        for (genvar j = 0; j < WEIGHT_COLUMNS; j++) begin : g_col
            for (genvar c = 0; c < IN_COLUMNS; c++) begin : g_k
                assign prod[(r*WEIGHT_COLUMNS+j)*IN_COLUMNS+c] =
                    a_el[r*IN_COLUMNS+c] * b_el[c*WEIGHT_COLUMNS+j];
            end
        end
    end

    // Join: a beat needs both operands and, on the last beat, room in the output register.
    assign last_beat     = (beat_cnt_q == LAST_BEAT);
    assign can_accept    = !rst && (!last_beat || !out_valid_q || data_out_ready);
    assign data_in_ready = weight_valid & can_accept;
    assign weight_ready  = data_in_valid & can_accept;
    assign beat          = data_in_valid & weight_valid & can_accept;

    always_comb begin
        for (int unsigned e = 0; e < NUM_C; e++) begin
            logic signed [ACC_WIDTH-1:0] sum;
            sum = acc_q[e];
            for (int unsigned c = 0; c < IN_COLUMNS; c++) begin
                sum = sum + ACC_WIDTH'(prod[e*IN_COLUMNS+c]);
            end
            final_sum[e] = sum;
        end
    end

    for (genvar e = 0; e < NUM_C; e++) begin : g_conv
        fixed_round_sat #(
            .IN_WIDTH (ACC_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .SHIFT    (OUT_SHIFT),
            .SATURATE (SATURATE)
        ) u_round_sat (
            .acc   (final_sum[e]),
            .result(conv[e])
        );
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        for (int unsigned e = 0; e < NUM_C; e++) begin
            acc_d[e] = acc_q[e];
        end
        if (out_valid_q && data_out_ready) begin
            out_valid_d = 1'b0;
        end
        if (beat) begin
            if (last_beat) begin
                beat_cnt_d  = '0;
                out_valid_d = 1'b1;
                for (int unsigned e = 0; e < NUM_C; e++) begin
                    acc_d[e] = '0;
                    out_d[e*OUT_WIDTH +: OUT_WIDTH] = conv[e];
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                for (int unsigned e = 0; e < NUM_C; e++) begin
                    acc_d[e] = final_sum[e];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int unsigned e = 0; e < NUM_C; e++) begin
                acc_q[e] <= '0;
            end
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            for (int unsigned e = 0; e < NUM_C; e++) begin
                acc_q[e] <= acc_d[e];
            end
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_matmul_tiled.sv
// Bench: a depth-3 instance checked cycle by cycle against a tile-level model, plus three
// depth-1 instances (identity, saturating and truncating narrow outputs) driven in lockstep.
module tb_fixed_matmul_tiled;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] data_in, weight;
    logic         a_dv, a_wv, a_dor, b_dv, b_wv, b_dor;
    logic [255:0] m_out, i_out;
    logic [127:0] s_out, t_out;
    logic m_ov, m_dr, m_wr, i_ov, i_dr, i_wr, s_ov, s_dr, s_wr, t_ov, t_dr, t_wr;

    int total = 0;
    int bad = 0;
    int dut_beats = 0;
    int ta[N];
    int tb[N];
    longint macc[N];
    longint mout[N];
    bit mvalid;
    int mcnt;

    fixed_matmul_tiled #(.IN_DEPTH(3), .OUT_WIDTH(16), .OUT_SHIFT(0), .SATURATE(1)) u_main (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(a_dv), .data_in_ready(m_dr),
        .weight(weight), .weight_valid(a_wv), .weight_ready(m_wr),
        .data_out(m_out), .data_out_valid(m_ov), .data_out_ready(a_dor));

    fixed_matmul_tiled #(.IN_DEPTH(1), .OUT_WIDTH(16), .OUT_SHIFT(0), .SATURATE(1)) u_id (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(b_dv), .data_in_ready(i_dr),
        .weight(weight), .weight_valid(b_wv), .weight_ready(i_wr),
        .data_out(i_out), .data_out_valid(i_ov), .data_out_ready(b_dor));

    fixed_matmul_tiled #(.IN_DEPTH(1), .OUT_WIDTH(8), .OUT_SHIFT(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(b_dv), .data_in_ready(s_dr),
        .weight(weight), .weight_valid(b_wv), .weight_ready(s_wr),
        .data_out(s_out), .data_out_valid(s_ov), .data_out_ready(b_dor));

    fixed_matmul_tiled #(.IN_DEPTH(1), .OUT_WIDTH(8), .OUT_SHIFT(4), .SATURATE(0)) u_trunc (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(b_dv), .data_in_ready(t_dr),
        .weight(weight), .weight_valid(b_wv), .weight_ready(t_wr),
        .data_out(t_out), .data_out_valid(t_ov), .data_out_ready(b_dor));

    // C(r,j) of the current A/B tile as plain integer arithmetic.
    function automatic longint prod_el(int e);
        longint s = 0;
        for (int c = 0; c < 4; c++) s += longint'(ta[(e/4)*4+c]) * longint'(tb[c*4+e%4]);
        return s;
    endfunction

    function automatic longint conv(longint x, int shift, int ow, bit sat);
        longint v, lim;
        v = x;
        if (shift > 0) v = (x + (longint'(1) <<< (shift-1))) >>> shift;
        lim = longint'(1) <<< (ow-1);
        if (sat) begin
            if (v > lim - 1) v = lim - 1;
            else if (v < -lim) v = -lim;
        end else begin
            v = v & ((lim <<< 1) - 1);
            if (v >= lim) v -= (lim <<< 1);
        end
        return v;
    endfunction

    function automatic longint el16(logic [255:0] v, int e);
        logic signed [15:0] t;
        t = v[e*16 +: 16];
        return longint'(t);
    endfunction

    function automatic longint el8(logic [127:0] v, int e);
        logic signed [7:0] t;
        t = v[e*8 +: 8];
        return longint'(t);
    endfunction

    task automatic set_tile();
        for (int i = 0; i < N; i++) begin
            data_in[i*8 +: 8] = ta[i][7:0];
            weight[i*8 +: 8]  = tb[i][7:0];
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < N; e++) begin
            macc[e] = 0;
            mout[e] = 0;
        end
        mvalid = 0;
        mcnt   = 0;
    endtask

    // One cycle of the depth-3 instance: drive, check against the model, advance the model.
    task automatic step_main(input bit dv, input bit wv, input bit dor);
        bit can, took;
        logic [255:0] exp_v;
        longint fin;
        a_dv = dv; a_wv = wv; a_dor = dor;
        set_tile();
        @(negedge clk);
        can = (mcnt < 2) || !mvalid || dor;
        for (int e = 0; e < N; e++) exp_v[e*16 +: 16] = mout[e][15:0];
        total++;
        if ({m_dr, m_wr} !== {wv & can, dv & can}) begin
            bad++;
            $display("FAIL main_ready: got %b%b want %b%b", m_dr, m_wr, wv & can, dv & can);
        end
        total++;
        if (m_ov !== mvalid) begin
            bad++;
            $display("FAIL main_valid: got %b want %b", m_ov, mvalid);
        end
        total++;
        if (m_out !== exp_v) begin
            bad++;
            $display("FAIL main_data: got %h want %h", m_out, exp_v);
        end
        if (m_dr && m_wr && dv && wv) dut_beats++;
        took = dv & wv & can;
        if (mvalid && dor) mvalid = 0;
        if (took) begin
            for (int e = 0; e < N; e++) begin
                fin = macc[e] + prod_el(e);
                if (mcnt == 2) begin
                    mout[e] = conv(fin, 0, 16, 1);
                    macc[e] = 0;
                end else begin
                    macc[e] = fin;
                end
            end
            if (mcnt == 2) begin
                mvalid = 1;
                mcnt   = 0;
            end else begin
                mcnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    // One beat into the depth-1 instances, then check all three outputs.
    task automatic beat_b();
        b_dv = 1; b_wv = 1; b_dor = 1;
        set_tile();
        @(negedge clk);
        total++;
        if ({i_dr, i_wr, s_dr, s_wr, t_dr, t_wr} !== 6'b111111) begin
            bad++;
            $display("FAIL b_ready: got %b%b%b%b%b%b want 111111", i_dr, i_wr, s_dr, s_wr,
                     t_dr, t_wr);
        end
        @(posedge clk); #1;
        b_dv = 0; b_wv = 0;
        @(negedge clk);
        total++;
        if ({i_ov, s_ov, t_ov} !== 3'b111) begin
            bad++;
            $display("FAIL b_valid: got %b%b%b want 111", i_ov, s_ov, t_ov);
        end
        for (int e = 0; e < N; e++) begin
            total++;
            if (el16(i_out, e) !== conv(prod_el(e), 0, 16, 1)) begin
                bad++;
                $display("FAIL b_ident[%0d]: got %0d want %0d", e, el16(i_out, e),
                         conv(prod_el(e), 0, 16, 1));
            end
            total++;
            if (el8(s_out, e) !== conv(prod_el(e), 4, 8, 1)) begin
                bad++;
                $display("FAIL b_sat[%0d]: got %0d want %0d", e, el8(s_out, e),
                         conv(prod_el(e), 4, 8, 1));
            end
            total++;
            if (el8(t_out, e) !== conv(prod_el(e), 4, 8, 0)) begin
                bad++;
                $display("FAIL b_trunc[%0d]: got %0d want %0d", e, el8(t_out, e),
                         conv(prod_el(e), 4, 8, 0));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input bit check);
        rst = 1;
        a_dv = 1; a_wv = 1; b_dv = 1; b_wv = 1; a_dor = 0; b_dor = 0;
        @(posedge clk); #1;
        @(negedge clk);
        if (check) begin
            total++;
            if ({m_dr, m_wr, i_dr, i_wr, s_dr, s_wr, t_dr, t_wr} !== 8'h00) begin
                bad++;
                $display("FAIL reset_ready: got %b%b%b%b%b%b%b%b want 0", m_dr, m_wr, i_dr,
                         i_wr, s_dr, s_wr, t_dr, t_wr);
            end
            total++;
            if ({m_ov, i_ov, s_ov, t_ov} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_valid: got %b%b%b%b want 0000", m_ov, i_ov, s_ov, t_ov);
            end
            total++;
            if ({m_out, i_out, s_out, t_out} !== '0) begin
                bad++;
                $display("FAIL reset_data: got %h %h want 0", m_out, s_out);
            end
        end
        @(posedge clk); #1;
        rst = 0;
        a_dv = 0; a_wv = 0; b_dv = 0; b_wv = 0;
        model_reset();
    endtask

    task automatic rand_tile();
        for (int i = 0; i < N; i++) begin
            ta[i] = int'($urandom_range(0, 255)) - 128;
            tb[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
    endtask

    task automatic test_identity();
        logic [255:0] exp_v;
        for (int i = 0; i < N; i++) ta[i] = (i / 4 == i % 4) ? 1 : 0;
        b_dv = 1; b_wv = 1; b_dor = 1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) tb[i] = i + k * 16;
            set_tile();
            @(negedge clk);
            total++;
            if ({i_dr, i_wr} !== 2'b11) begin
                bad++;
                $display("FAIL ident_ready: beat %0d got %b%b want 11", k, i_dr, i_wr);
            end
            if (k > 0) begin
                for (int i = 0; i < N; i++) exp_v[i*16 +: 16] = 16'(i + (k - 1) * 16);
                total++;
                if (i_ov !== 1'b1 || i_out !== exp_v) begin
                    bad++;
                    $display("FAIL ident_stream: beat %0d got %b/%h want 1/%h", k, i_ov, i_out,
                             exp_v);
                end
            end
            @(posedge clk); #1;
        end
        b_dv = 0; b_wv = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) exp_v[i*16 +: 16] = 16'(i + 48);
        total++;
        if (i_ov !== 1'b1 || i_out !== exp_v) begin
            bad++;
            $display("FAIL ident_last: got %b/%h want 1/%h", i_ov, i_out, exp_v);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (i_ov !== 1'b0) begin
            bad++;
            $display("FAIL ident_drain: got %b want 0", i_ov);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_sat();
        for (int i = 0; i < N; i++) begin
            ta[i] = (i % 4 == 0) ? 1 : 0;
            tb[i] = (i < 4) ? 24 : 0;
        end
        beat_b();
        total++;
        if (el8(s_out, 5) !== 2 || el8(t_out, 5) !== 2) begin
            bad++;
            $display("FAIL round_pos: got %0d/%0d want 2/2", el8(s_out, 5), el8(t_out, 5));
        end
        for (int i = 0; i < 4; i++) tb[i] = -24;
        beat_b();
        total++;
        if (el8(s_out, 9) !== -1 || el8(t_out, 9) !== -1) begin
            bad++;
            $display("FAIL round_neg: got %0d/%0d want -1/-1", el8(s_out, 9), el8(t_out, 9));
        end
        for (int i = 0; i < N; i++) begin
            ta[i] = 127;
            tb[i] = 127;
        end
        beat_b();
        total++;
        if (el8(s_out, 0) !== 127 || el8(t_out, 0) !== -64 || el16(i_out, 0) !== 32767) begin
            bad++;
            $display("FAIL sat_max: got %0d/%0d/%0d want 127/-64/32767", el8(s_out, 0),
                     el8(t_out, 0), el16(i_out, 0));
        end
    endtask

    task automatic test_depth_accumulate();
        for (int i = 0; i < N; i++) begin
            ta[i] = 1;
            tb[i] = 2;
        end
        for (int k = 0; k < 3; k++) step_main(1, 1, 1);
        total++;
        if (m_ov !== 1'b1 || el16(m_out, 0) !== 24 || el16(m_out, 15) !== 24) begin
            bad++;
            $display("FAIL depth_acc: got %b/%0d/%0d want 1/24/24", m_ov, el16(m_out, 0),
                     el16(m_out, 15));
        end
        step_main(0, 0, 1);
        step_main(0, 0, 1);
    endtask

    task automatic test_join_skew();
        rand_tile();
        for (int k = 0; k < 3; k++) step_main(0, 1, 1);
        dut_beats = 0;
        step_main(1, 1, 1);
        total++;
        if (dut_beats !== 1) begin
            bad++;
            $display("FAIL join_single: got %0d beats want 1", dut_beats);
        end
        step_main(1, 1, 1);
        step_main(1, 1, 1);
        step_main(0, 0, 1);
        step_main(0, 0, 1);
    endtask

    task automatic test_back_pressure();
        rand_tile();
        for (int k = 0; k < 3; k++) step_main(1, 1, 1);
        rand_tile();
        dut_beats = 0;
        for (int k = 0; k < 10; k++) step_main(1, 1, 0);
        total++;
        if (dut_beats !== 2) begin
            bad++;
            $display("FAIL bp_beats: got %0d want 2", dut_beats);
        end
        step_main(1, 1, 1);
        step_main(0, 0, 1);
        step_main(0, 0, 1);
    endtask

    task automatic test_mid_reset();
        rand_tile();
        for (int k = 0; k < 3; k++) step_main(1, 1, 0);
        rand_tile();
        step_main(1, 1, 0);
        step_main(1, 1, 0);
        apply_reset(1'b1);
        rand_tile();
        for (int k = 0; k < 3; k++) step_main(1, 1, 1);
        step_main(0, 0, 1);
        step_main(0, 0, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            rand_tile();
            step_main($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0);
        end
        for (int k = 0; k < 30; k++) begin
            rand_tile();
            beat_b();
        end
    endtask

    initial begin
        rst = 1;
        a_dv = 0; a_wv = 0; a_dor = 0; b_dv = 0; b_wv = 0; b_dor = 0;
        data_in = '0;
        weight = '0;
        model_reset();
        test_reset();
        test_identity();
        test_round_sat();
        test_depth_accumulate();
        test_join_skew();
        test_back_pressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
